interrupt_arbiter: RTL

Parametrised interrupt front end for the 6502 core, replacing the single-IRQ/single-NMI controller. It takes NUM_IRQ active-low IRQ sources (APU frame counter, DMC, mapper, …), each configurable as level or edge, plus the PPU NMI line. It keeps per-source pending state, applies enables and the CPU I flag, and raises a perform-interrupt request at CPU poll points. It also reports which vector to fetch and which source won priority.

---
 rtl/interrupt_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/interrupt_arbiter.sv
// Interrupt front end for the 6502 core: NUM_IRQ level/edge IRQ sources plus NMI,
// pending tracking, priority id, and a two-state perform-interrupt request FSM.

module irq_src_cell #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_ph1,
  input  logic rst,
  input  logic irq_n,
  input  logic ack,
  output logic pending
);
  logic irq_r, irq_prev;

  // Both sample registers load the live line during reset, so a line that is
  // already low at release is not mistaken for a falling edge.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      irq_r    <= irq_n;
      irq_prev <= irq_n;
      pending  <= 1'b0;
    end else begin
      irq_r    <= irq_n;
      irq_prev <= irq_r;
      if (EDGE) pending <= (irq_prev & ~irq_r) | (pending & ~ack);
      else      pending <= ~irq_r;
    end
  end
endmodule

module interrupt_arbiter #(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE = '0,
  parameter int                 IDW       = 2
) (
  input  logic               clk_ph1,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic [NUM_IRQ-1:0] irq_ack,
  input  logic               nmi_n,
  input  logic               i_flag,
  input  logic               poll,
  input  logic               int_ack,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_line,
  output logic [IDW-1:0]     irq_id,
  output logic               nmi_pending,
  output logic               int_req,
  output logic               int_src,
  output logic [15:0]        vec_addr
);
  typedef enum logic {IDLE, ARMED} state_t;

  typedef struct packed {
    logic        src;
    logic [15:0] vec;
  } req_t;

  state_t         state, state_nxt;
  req_t           req, req_nxt;
  logic           nmi_r, nmi_prev, nmi_clr;
  logic [IDW-1:0] id_nxt;

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_src
      irq_src_cell #(.EDGE(EDGE_MODE[g])) u_src (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .irq_n   (irq_n[g]),
        .ack     (irq_ack[g]),
        .pending (irq_pending[g])
      );
    end
  endgenerate

  assign irq_line = |(irq_pending & irq_en);
  assign int_req  = (state == ARMED);
  assign int_src  = req.src;
  assign vec_addr = req.vec;
  assign nmi_clr  = (state == ARMED) && int_ack && req.src;

  always_comb begin
    id_nxt = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_pending[i] && irq_en[i]) id_nxt = IDW'(i);
  end

  always_comb begin
    state_nxt   = state;
    req_nxt.src = req.src;
    case (state)
      IDLE: begin
        if (poll && nmi_pending) begin
          state_nxt   = ARMED;
          req_nxt.src = 1'b1;
        end else if (poll && irq_line && !i_flag) begin
          state_nxt   = ARMED;
          req_nxt.src = 1'b0;
        end
      end
      ARMED: begin
        // An armed IRQ is never withdrawn; only an NMI can take it over.
        if (int_ack)                       state_nxt   = IDLE;
        else if (!req.src && nmi_pending)  req_nxt.src = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    req_nxt.vec = req_nxt.src ? 16'hFFFA : 16'hFFFE;
  end

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state       <= IDLE;
      req         <= '{src: 1'b0, vec: 16'hFFFE};
      irq_id      <= '0;
      nmi_r       <= nmi_n;
      nmi_prev    <= nmi_n;
      nmi_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      req         <= req_nxt;
      irq_id      <= id_nxt;
      nmi_r       <= nmi_n;
      nmi_prev    <= nmi_r;
      nmi_pending <= (nmi_prev & ~nmi_r) | (nmi_pending & ~nmi_clr);
    end
  end
endmodule
